// File: rtl/direct_mapped_cache.sv
// Direct-mapped, read-only cache in front of main_memory: one request in flight,
// 4-word line fill on a miss, and saturating access/hit statistics.
module direct_mapped_cache #(
  parameter int WORD_LENGTH = 32,
  parameter int SETS        = 1024,
  parameter int ADDR_WIDTH  = 15,
  parameter int MEM_LATENCY = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_WIDTH-1:0]  req_address,
  output logic                   resp_valid,
  output logic [WORD_LENGTH-1:0] resp_data,
  output logic                   resp_hit,
  output logic [ADDR_WIDTH-1:0]  mem_address,
  output logic                   mem_hit,
  input  logic [WORD_LENGTH-1:0] mem_data1,
  input  logic [WORD_LENGTH-1:0] mem_data2,
  input  logic [WORD_LENGTH-1:0] mem_data3,
  input  logic [WORD_LENGTH-1:0] mem_data4,
  output logic [CNT_WIDTH-1:0]   access_count,
  output logic [CNT_WIDTH-1:0]   hit_count
);

  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_WIDTH - IDX_W - 2;
  localparam int WAIT_W = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(MEM_LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_RESP
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [WAIT_W-1:0]       wait_q;
  logic [SETS-1:0]         valid_q;
  logic [TAG_W-1:0]        tag_q  [SETS];
  logic [WORD_LENGTH-1:0]  data_q [SETS][4];

  logic [1:0]              off;
  logic [IDX_W-1:0]        idx;
  logic [TAG_W-1:0]        tag;
  logic                    hit_w;
  logic                    fill_done;
  logic [WORD_LENGTH-1:0]  cache_word;
  logic [WORD_LENGTH-1:0]  fill_word;
  logic [CNT_WIDTH-1:0]    access_d;
  logic [CNT_WIDTH-1:0]    hit_d;

  // Statistics stick at all-ones instead of wrapping.
  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  assign off        = addr_q[1:0];
  assign idx        = addr_q[IDX_W+1:2];
  assign tag        = addr_q[ADDR_WIDTH-1:IDX_W+2];
  assign hit_w      = valid_q[idx] && (tag_q[idx] == tag);
  assign cache_word = data_q[idx][off];
  assign fill_done  = (state_q == S_FILL) && (wait_q == '0);
  assign access_d   = sat_inc(access_count);
  assign hit_d      = sat_inc(hit_count);

  always_comb begin
    fill_word = mem_data1;
    case (off)
      2'd0:    fill_word = mem_data1;
      2'd1:    fill_word = mem_data2;
      2'd2:    fill_word = mem_data3;
      default: fill_word = mem_data4;
    endcase
  end

  // Line storage needs no reset; validity lives in valid_q.
  always_ff @(posedge clk) begin
    if (fill_done) begin
      data_q[idx][0] <= mem_data1;
      data_q[idx][1] <= mem_data2;
      data_q[idx][2] <= mem_data3;
      data_q[idx][3] <= mem_data4;
      tag_q[idx]     <= tag;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wait_q       <= '0;
      valid_q      <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_data    <= '0;
      resp_hit     <= 1'b0;
      mem_address  <= '0;
      mem_hit      <= 1'b1;
      access_count <= '0;
      hit_count    <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (req_valid) begin
            addr_q    <= req_address;
            req_ready <= 1'b0;
            state_q   <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          access_count <= access_d;
          if (hit_w) begin
            resp_data  <= cache_word;
            resp_hit   <= 1'b1;
            resp_valid <= 1'b1;
            hit_count  <= hit_d;
            state_q    <= S_RESP;
          end else begin
            mem_address <= addr_q;
            mem_hit     <= 1'b0;
            wait_q      <= WAIT_INIT;
            state_q     <= S_FILL;
          end
        end
        S_FILL: begin
          // mem_data is only trusted on the final FILL edge.
          if (wait_q == '0) begin
            valid_q[idx] <= 1'b1;
            resp_data    <= fill_word;
            resp_hit     <= 1'b0;
            resp_valid   <= 1'b1;
            mem_hit      <= 1'b1;
            state_q      <= S_RESP;
          end else begin
            wait_q <= wait_q - WAIT_W'(1);
          end
        end
        S_RESP: begin
          resp_valid <= 1'b0;
          req_ready  <= 1'b1;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_direct_mapped_cache.sv
// Randomized and directed bench for direct_mapped_cache against a transaction-level
// model of the cache and a latency-aware main_memory stand-in.
module tb_direct_mapped_cache;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [14:0] req_address = '0;

  logic        req_ready, resp_valid, resp_hit, mem_hit;
  logic [31:0] resp_data;
  logic [14:0] mem_address;
  logic [15:0] access_count, hit_count;
  logic [31:0] mem_data1, mem_data2, mem_data3, mem_data4;

  logic        s_req_ready, s_resp_valid, s_resp_hit, s_mem_hit;
  logic [31:0] s_resp_data;
  logic [14:0] s_mem_address;
  logic [1:0]  s_access_count, s_hit_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  direct_mapped_cache #(.WORD_LENGTH(32), .SETS(1024), .ADDR_WIDTH(15),
                        .MEM_LATENCY(LAT), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_address(req_address), .resp_valid(resp_valid), .resp_data(resp_data),
    .resp_hit(resp_hit), .mem_address(mem_address), .mem_hit(mem_hit),
    .mem_data1(mem_data1), .mem_data2(mem_data2), .mem_data3(mem_data3),
    .mem_data4(mem_data4), .access_count(access_count), .hit_count(hit_count));

  direct_mapped_cache #(.WORD_LENGTH(32), .SETS(1024), .ADDR_WIDTH(15),
                        .MEM_LATENCY(LAT), .CNT_WIDTH(2)) u_sat (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(s_req_ready),
    .req_address(req_address), .resp_valid(s_resp_valid), .resp_data(s_resp_data),
    .resp_hit(s_resp_hit), .mem_address(s_mem_address), .mem_hit(s_mem_hit),
    .mem_data1(mem_data1), .mem_data2(mem_data2), .mem_data3(mem_data3),
    .mem_data4(mem_data4), .access_count(s_access_count), .hit_count(s_hit_count));

  // main_memory contents: RAM[1024+i] = i
  function automatic logic [31:0] memword(input logic [14:0] a);
    return 32'(a) - 32'd1024;
  endfunction

  // Memory stand-in: block words appear only after MEM_LATENCY-1 low cycles of mem_hit.
  int low_cnt;
  logic [14:0] mbase;
  logic        mem_rdy;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)       low_cnt <= 0;
    else if (mem_hit) low_cnt <= 0;
    else              low_cnt <= low_cnt + 1;
  end
  assign mbase     = {mem_address[14:2], 2'b00};
  assign mem_rdy   = !mem_hit && (low_cnt >= LAT - 1);
  assign mem_data1 = mem_rdy ? memword(mbase)         : 32'hDEAD_BEE0;
  assign mem_data2 = mem_rdy ? memword(mbase + 15'd1) : 32'hDEAD_BEE1;
  assign mem_data3 = mem_rdy ? memword(mbase + 15'd2) : 32'hDEAD_BEE2;
  assign mem_data4 = mem_rdy ? memword(mbase + 15'd3) : 32'hDEAD_BEE3;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: which lines are present, and when each transaction's effects appear.
  bit          mv_valid [1024];
  bit [2:0]    mv_tag   [1024];
  bit          busy;
  int          k, lat;
  bit          cur_hit;
  logic [14:0] cur_addr;
  logic        e_ready, e_rv, e_rhit, e_mhit;
  logic [31:0] e_data;
  logic [14:0] e_maddr;
  int          e_acc, e_hits;

  function automatic bit model_hit(input logic [14:0] a);
    return mv_valid[a[11:2]] && (mv_tag[a[11:2]] == a[14:12]);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0; k <= 0; lat <= 0; cur_hit <= 1'b0; cur_addr <= '0;
      e_ready <= 1'b1; e_rv <= 1'b0; e_data <= '0; e_rhit <= 1'b0;
      e_mhit <= 1'b1; e_maddr <= '0; e_acc <= 0; e_hits <= 0;
      for (int i = 0; i < 1024; i++) mv_valid[i] <= 1'b0;
    end else if (busy) begin
      k    <= k + 1;
      e_rv <= (k + 1 == lat);
      if (k + 1 == 1) begin
        e_acc <= e_acc + 1;
        if (cur_hit) e_hits <= e_hits + 1;
        else begin
          e_mhit  <= 1'b0;
          e_maddr <= cur_addr;
        end
      end
      if (k + 1 == lat) begin
        e_data <= memword(cur_addr);
        e_rhit <= cur_hit;
        e_mhit <= 1'b1;
        if (!cur_hit) begin
          mv_valid[cur_addr[11:2]] <= 1'b1;
          mv_tag[cur_addr[11:2]]   <= cur_addr[14:12];
        end
      end
      if (k + 1 == lat + 1) begin
        busy    <= 1'b0;
        e_ready <= 1'b1;
      end
    end else if (req_valid) begin
      busy     <= 1'b1;
      k        <= 0;
      cur_addr <= req_address;
      cur_hit  <= model_hit(req_address);
      lat      <= model_hit(req_address) ? 1 : 1 + LAT;
      e_ready  <= 1'b0;
    end
  end

  function automatic logic [31:0] satn(input int v, input int mx);
    return 32'((v > mx) ? mx : v);
  endfunction

  always @(negedge clk) begin
    chk("req_ready",    32'(req_ready),    32'(e_ready));
    chk("resp_valid",   32'(resp_valid),   32'(e_rv));
    chk("resp_data",    resp_data,         e_data);
    chk("resp_hit",     32'(resp_hit),     32'(e_rhit));
    chk("mem_hit",      32'(mem_hit),      32'(e_mhit));
    chk("mem_address",  32'(mem_address),  32'(e_maddr));
    chk("access_count", 32'(access_count), satn(e_acc, 65535));
    chk("hit_count",    32'(hit_count),    satn(e_hits, 65535));
    chk("sat_resp_valid",   32'(s_resp_valid),   32'(e_rv));
    chk("sat_resp_data",    s_resp_data,         e_data);
    chk("sat_access_count", 32'(s_access_count), satn(e_acc, 3));
    chk("sat_hit_count",    32'(s_hit_count),    satn(e_hits, 3));
  end

  int acc_mon = 0;
  int rv_mon = 0;
  always @(posedge clk) if (rst_n && req_valid && req_ready) acc_mon <= acc_mon + 1;
  always @(negedge clk) if (resp_valid) rv_mon <= rv_mon + 1;

  task automatic wait_ready();
    int w = 0;
    while (!req_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    chk("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  // Single read with literal expectations; entered and left at #1 after a rising edge.
  task automatic do_read(input logic [14:0] a, input logic [31:0] exp_d, input logic exp_h,
                         input int exp_lat, input int exp_low);
    int n = 0;
    int low = 0;
    wait_ready();
    req_valid = 1'b1; req_address = a;
    @(posedge clk); #1;
    req_valid = 1'b0;
    while (!resp_valid && n < 40) begin
      @(posedge clk); #1; n++;
      if (!mem_hit) begin
        low++;
        chk("fill_mem_address", 32'(mem_address), 32'(a));
      end
    end
    chk("latency",      32'(n),         32'(exp_lat));
    chk("rd_data",      resp_data,      exp_d);
    chk("rd_hit",       32'(resp_hit),  32'(exp_h));
    chk("mem_hit_low",  32'(low),       32'(exp_low));
    @(posedge clk); #1;
    chk("resp_pulse",   32'(resp_valid), 32'd0);
  endtask

  function automatic logic [14:0] rand_addr();
    int t = $urandom_range(1, 3);
    int i = $urandom_range(0, 7);
    int o = $urandom_range(0, 3);
    return {3'(t), 10'(i), 2'(o)};
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [14:0] hv [3];
    int a0, r0;
    hv[0] = 15'd1026; hv[1] = 15'd3000; hv[2] = 15'd1027;

    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_ready",    32'(req_ready),    32'd1);
    chk("rst_mem_hit",  32'(mem_hit),      32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_data",  resp_data,       32'd0);
    chk("rst_access",   32'(access_count), 32'd0);
    chk("rst_hits",     32'(hit_count),    32'd0);

    // Cold miss, then hits in the same line.
    do_read(15'd1024, 32'd0, 1'b0, 1 + LAT, LAT);
    chk("cold_access", 32'(access_count), 32'd1);
    chk("cold_hits",   32'(hit_count),    32'd0);
    do_read(15'd1025, 32'd1, 1'b1, 1, 0);
    do_read(15'd1026, 32'd2, 1'b1, 1, 0);
    do_read(15'd1027, 32'd3, 1'b1, 1, 0);
    chk("line_hits", 32'(hit_count), 32'd3);

    // Conflict on index 256.
    do_read(15'd5120, 32'd4096, 1'b0, 1 + LAT, LAT);
    do_read(15'd1024, 32'd0,    1'b0, 1 + LAT, LAT);
    do_read(15'd1025, 32'd1,    1'b1, 1, 0);

    // req_valid held high across three requests.
    a0 = acc_mon; r0 = rv_mon;
    req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_address = hv[i];
      wait_ready();
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    chk("held_accepts", 32'(acc_mon - a0), 32'd3);
    chk("held_resps",   32'(rv_mon - r0),  32'd3);

    // Reset in the middle of a fill.
    wait_ready();
    req_valid = 1'b1; req_address = 15'd2048;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    chk("fill_started", 32'(mem_hit), 32'd0);
    @(posedge clk); #1;
    r0 = rv_mon;
    rst_n = 1'b0;
    #1;
    chk("abort_mem_hit", 32'(mem_hit),      32'd1);
    chk("abort_access",  32'(access_count), 32'd0);
    chk("abort_rv",      32'(resp_valid),   32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) begin @(posedge clk); #1; end
    chk("abort_no_resp", 32'(rv_mon - r0), 32'd0);
    do_read(15'd2048, 32'd1024, 1'b0, 1 + LAT, LAT);

    // Saturation of the 2-bit counters.
    do_read(15'd1025, 32'd1, 1'b0, 1 + LAT, LAT);
    repeat (5) do_read(15'd1025, 32'd1, 1'b1, 1, 0);
    chk("sat_hits_pinned",   32'(s_hit_count),    32'd3);
    chk("sat_access_pinned", 32'(s_access_count), 32'd3);
    chk("wide_hits",         32'(hit_count),      32'd5);
    chk("wide_access",       32'(access_count),   32'd7);

    // Random traffic, including req_valid asserted while busy.
    repeat (3000) begin
      req_valid   = ($urandom_range(0, 2) != 0);
      req_address = rand_addr();
      @(posedge clk); #1;
    end
    req_valid = 1'b0;
    repeat (20) begin @(posedge clk); #1; end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/direct_mapped_cache.md
Name: direct_mapped_cache

Overview:
- Direct-mapped, read-only cache between the processor-side request port and main_memory.
- On a lookup it checks tag and valid. On a miss it drives main_memory's address/hit inputs, waits a fixed memory latency, and consumes the returned 4-word block (dataOut1..4) into one line.
- Returns the requested word with a hit/miss flag and keeps hit/access statistics.

Parameters:
- WORD_LENGTH, 32: data word width; must match the main_memory word width.
- SETS, 1024: number of lines; power of two. Index width = log2(SETS) = 10.
- ADDR_WIDTH, 15: word address width. Fields: offset = [1:0], index = [11:2], tag = [14:12].
- MEM_LATENCY, 4: cycles spent in FILL before the block is sampled; legal values ≥1.
- CNT_WIDTH, 16: width of the statistics counters.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  1  processor read request
- req_ready  output  1  high only in IDLE
- req_address  input  ADDR_WIDTH  word address
- resp_valid  output  1  one-cycle response pulse
- resp_data  output  WORD_LENGTH  returned word
- resp_hit  output  1  1 = served from cache, 0 = filled from memory
- mem_address  output  ADDR_WIDTH  address driven to main_memory
- mem_hit  output  1  drives main_memory hit input; 0 = read requested
- mem_data1..mem_data4  input  WORD_LENGTH each  block words at offsets 00, 01, 10, 11
- access_count  output  CNT_WIDTH  accepted requests
- hit_count  output  CNT_WIDTH  hits

Behaviour:
- Reset: rst_n low acts asynchronously.
  - State goes to IDLE; all valid bits are cleared.
  - Outputs: req_ready=1, resp_valid=0, resp_data=0, resp_hit=0, mem_address=0, mem_hit=1, both counters 0.
  - Tag and data arrays need no reset.
- States: IDLE, LOOKUP, FILL, RESP.
- IDLE:
  - A request is accepted on the edge where req_valid && req_ready; req_address is captured into addr_q.
  - Next state is LOOKUP.
- LOOKUP (one cycle):
  - Read valid[idx] and tag[idx]; access_count increments.
  - Hit: resp_data = line word at the offset, resp_hit=1, hit_count increments, next state RESP.
  - Miss: mem_address = addr_q, mem_hit=0, wait counter = MEM_LATENCY-1, next state FILL.
- FILL:
  - mem_hit stays 0 and mem_address stays stable; the counter decrements each cycle.
  - On the edge where the counter is 0:
    - write {mem_data1..4} into line idx, set tag[idx] = addr_q tag, set valid[idx]=1;
    - resp_data = the mem_data word selected by the offset, resp_hit=0;
    - mem_hit returns to 1; next state RESP.
- RESP:
  - resp_valid=1 for exactly one cycle; req_ready=0; next state IDLE.
  - resp_data and resp_hit hold until the next response.
- Latency, with the accept edge as E0:
  - hit: resp_valid is high in the cycle after E1;
  - miss: resp_valid is high in the cycle after E(1+MEM_LATENCY).
- Throughput:
  - Minimum issue interval is 3 cycles for hits and 3+MEM_LATENCY for misses.
  - req_valid held high while busy is ignored; there is no queueing.
- Line replacement: a conflict miss overwrites the line unconditionally. The cache is read-only, so there is no write-back.
- Counters saturate at all-ones and do not wrap.
- mem_hit is 0 only in FILL, so main_memory's outputs are high-Z outside FILL. Output data must never be sampled from mem_data outside the final FILL edge.
- Reset mid-FILL: abort; no line is written, no response is issued, mem_hit returns to 1 immediately.

Test Plan:
All scenarios use main_memory's initial contents: RAM[SETS+i] = i.
- Cold read 1024 after reset -> resp_valid 1+4 cycles after accept; data=0, resp_hit=0; mem_hit low exactly 4 cycles with mem_address=1024; access=1, hit=0.
- Then read 1025, 1026, 1027 -> each is a hit one cycle after LOOKUP; data 1, 2, 3; resp_hit=1; mem_hit never drops; hit_count=3.
- Conflict: read 5120 (same index 256, tag 1) -> miss, data=4096. Then read 1024 -> miss again, data=0. Then read 1025 -> hit, data=1.
- req_valid held high continuously over 3 addresses -> req_ready pulses only in IDLE; exactly 3 accepts and 3 single-cycle resp_valid pulses, in order.
- Assert rst_n low for 1 cycle during FILL of 2048 -> no resp_valid; mem_hit=1 immediately; counters 0. Re-read 2048 -> miss, data=1024.
- Counter saturation: run with CNT_WIDTH=2 for 5 hits -> hit_count stays 3.
